axi_line_fill: RTL and testbench
================================

AXI_LINE_FILL -- requirements
Module: axi_line_fill

Interface
REQ-001 Parameters (name, default, meaning): ID_WIDTH, 13, AXI ID width; ADDR_WIDTH, 64, address width; DATA_WIDTH, 64, beat width; FILL_ID, 0, constant ARID value.
REQ-002 Ports (name, direction, width, meaning): clk in 1 clock; reset in 1 reset (synchronous, active-high).
REQ-003 req_valid in 1, req_addr in ADDR_WIDTH, req_ready out 1: line fill request from LLC miss path.
REQ-004 m_axi_arvalid out 1, m_axi_arready in 1, m_axi_araddr out ADDR_WIDTH, m_axi_arid out ID_WIDTH, m_axi_arlen out 8, m_axi_arsize out 3, m_axi_arburst out 2.
REQ-005 m_axi_rvalid in 1, m_axi_rready out 1, m_axi_rdata in DATA_WIDTH, m_axi_rresp in 2, m_axi_rlast in 1, m_axi_rid in ID_WIDTH.
REQ-006 line_valid out 1, line_ready in 1, line_data out 512, line_addr out ADDR_WIDTH (64-byte aligned), line_err out 1.
REQ-007 cw_valid out 1, cw_data out DATA_WIDTH: critical-word early forward (present only with LINE_FILL_CWF_EN).

Function
REQ-008 Constants: arlen=8'd7, arsize=3'b011, arburst=2'b10 (WRAP), arid=FILL_ID.
REQ-009 FSM states IDLE, ADDR, DATA, RESP; req_ready=1 only in IDLE.
REQ-010 IDLE: req_valid&&req_ready latches req_addr and moves to ADDR; arvalid is asserted the next cycle.
REQ-011 m_axi_araddr={req_addr[63:3],3'b000}; the burst starts at the critical word.
REQ-012 ADDR: arvalid and araddr are held stable until arready; after the handshake, the FSM moves to DATA and arvalid drops the next cycle.
REQ-013 DATA: rready=1; the beat index is initialised to req_addr[5:3] and increments modulo 8 on each accepted beat (wrap).
REQ-014 Each accepted beat is written to line_data[idx*64 +: 64]; a beat is accepted when rvalid&&rready.
REQ-015 A 3-bit beat counter counts accepted beats; the fill completes on rlast or on the 8th beat, whichever comes first, and the FSM moves to RESP.
REQ-016 line_err is sticky per fill; it is set if any beat has rresp[1]=1, or if rlast does not coincide with the 8th beat.
REQ-017 rid is not checked; a single outstanding burst is guaranteed.
REQ-018 RESP: line_valid=1; line_data, line_addr={addr[63:6],6'b0} and line_err are held stable until line_ready; on the handshake, the FSM returns to IDLE next cycle and line_err clears.
REQ-019 Minimum latency with arready=1 and rvalid=1 every cycle: request accepted at cycle 0, AR handshake at cycle 1, beats at cycles 2-9, line_valid at cycle 10.
REQ-020 A new req_valid during ADDR/DATA/RESP is not accepted (req_ready=0); the requester holds it.
REQ-021 rvalid in IDLE/ADDR/RESP is ignored (rready=0).

Reset
REQ-022 Reset forces IDLE, arvalid=0, rready=0, line_valid=0, line_err=0, cw_valid=0, beat counter=0, line_data=0, line_addr=0.
REQ-023 Reset mid-burst abandons the fill without draining; bus reset is concurrent system-wide.

Configuration
REQ-024 Macro LINE_FILL_CWF_EN defined: cw_valid pulses for exactly one cycle, the cycle after the first beat is accepted, with cw_data equal to that beat; this occurs regardless of line_ready.
REQ-025 Macro LINE_FILL_CWF_EN undefined: cw_valid and cw_data ports are absent; all other behaviour is identical.

Verification
REQ-026 req_addr=0x80001000, zero-wait slave, rdata=beat number k (0..7) -> araddr=0x80001000, line_data word k=k, line_valid at cycle 10, line_err=0.
REQ-027 req_addr=0x80001028 -> araddr=0x80001028; beats 0..7 land in words 5,6,7,0,1,2,3,4; line_addr=0x80001000.
REQ-028 Beat 3 with rresp=2'b10 -> line_err=1 in RESP; the next fill with clean responses -> line_err=0.
REQ-029 arready delayed 4 cycles, rvalid toggling, line_ready held low 5 cycles -> araddr and line_data stable throughout, req_ready=0 until the cycle after the line handshake.
REQ-030 rlast on the 6th beat -> line_err=1, line_valid the next cycle; reset asserted during DATA -> IDLE next cycle, arvalid=0, line_valid=0.
REQ-031 With LINE_FILL_CWF_EN, req_addr=0x40000018, first rdata=0xDEADBEEF -> a single cw_valid pulse with cw_data=0xDEADBEEF, one cycle after the first beat.

Source files
------------

// File: rtl/axi_line_fill.sv
// LLC miss line filler: one 8-beat AXI WRAP read per request, reassembled into a 64-byte line.
// Optional macro LINE_FILL_CWF_EN adds a critical-word early-forward port (cw_valid/cw_data).
module axi_line_fill #(
    parameter int                  ID_WIDTH   = 13,
    parameter int                  ADDR_WIDTH = 64,
    parameter int                  DATA_WIDTH = 64,
    parameter logic [ID_WIDTH-1:0] FILL_ID    = '0
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_ready,

    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,

    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,

    output logic                  line_valid,
    input  logic                  line_ready,
    output logic [511:0]          line_data,
    output logic [ADDR_WIDTH-1:0] line_addr,
    output logic                  line_err
`ifdef LINE_FILL_CWF_EN
    ,
    output logic                  cw_valid,
    output logic [DATA_WIDTH-1:0] cw_data
`endif
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            idx_q, idx_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [511:0]          line_data_q, line_data_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  line_valid_q, line_valid_d;
    logic                  req_ready_q, req_ready_d;
    logic                  cw_valid_q, cw_valid_d;
    logic [DATA_WIDTH-1:0] cw_data_q, cw_data_d;

    logic beat;
    logic last_beat;
    logic unused_bits;

    // rready is only ever high in DATA, so this also gates beats to that state
    assign beat      = rready_q && m_axi_rvalid;
    assign last_beat = (cnt_q == 3'd7);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        line_data_d  = line_data_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        line_valid_d = line_valid_q;
        req_ready_d  = req_ready_q;
        cw_valid_d   = 1'b0;
        cw_data_d    = cw_data_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d      = req_addr;
                    idx_d       = req_addr[5:3];
                    cnt_d       = 3'd0;
                    err_d       = 1'b0;
                    arvalid_d   = 1'b1;
                    req_ready_d = 1'b0;
                    state_d     = ADDR;
                end
            end
            ADDR: begin
                if (arvalid_q && m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (beat) begin
                    line_data_d[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] = m_axi_rdata;
                    idx_d = idx_q + 3'd1;
                    cnt_d = cnt_q + 3'd1;
                    // error on slave error or when rlast and the 8th beat disagree
                    if (m_axi_rresp[1] || (m_axi_rlast != last_beat)) begin
                        err_d = 1'b1;
                    end
                    if (cnt_q == 3'd0) begin
                        cw_valid_d = 1'b1;
                        cw_data_d  = m_axi_rdata;
                    end
                    if (m_axi_rlast || last_beat) begin
                        rready_d     = 1'b0;
                        line_valid_d = 1'b1;
                        state_d      = RESP;
                    end
                end
            end
            RESP: begin
                if (line_ready) begin
                    line_valid_d = 1'b0;
                    err_d        = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            idx_q        <= 3'd0;
            cnt_q        <= 3'd0;
            err_q        <= 1'b0;
            line_data_q  <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            line_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            cw_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            line_data_q  <= line_data_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            line_valid_q <= line_valid_d;
            req_ready_q  <= req_ready_d;
            cw_valid_q   <= cw_valid_d;
        end
    end

    // critical word only qualifies alongside cw_valid, so it needs no reset
    always_ff @(posedge clk) begin
        cw_data_q <= cw_data_d;
    end

    assign req_ready     = req_ready_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = {addr_q[ADDR_WIDTH-1:3], 3'b000};
    assign m_axi_arid    = FILL_ID;
    assign m_axi_arlen   = 8'd7;
    assign m_axi_arsize  = 3'b011;
    assign m_axi_arburst = 2'b10;
    assign m_axi_rready  = rready_q;
    assign line_valid    = line_valid_q;
    assign line_data     = line_data_q;
    assign line_addr     = {addr_q[ADDR_WIDTH-1:6], 6'b000000};
    assign line_err      = err_q;

`ifdef LINE_FILL_CWF_EN
    assign cw_valid    = cw_valid_q;
    assign cw_data     = cw_data_q;
    assign unused_bits = ^{m_axi_rid, m_axi_rresp[0], addr_q[2:0]};
`else
    assign unused_bits = ^{m_axi_rid, m_axi_rresp[0], addr_q[2:0], cw_valid_q, cw_data_q};
`endif

endmodule

// File: tb/tb_axi_line_fill.sv
// Directed self-checking bench for axi_line_fill; cw_* checks are active when LINE_FILL_CWF_EN is defined.
module tb_axi_line_fill;
    localparam int IW = 13;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam logic [63:0] BAD = 64'hBAD0_BAD0_BAD0_BAD0;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic [AW-1:0] req_addr;
    logic          req_ready;
    logic          m_axi_arvalid, m_axi_arready;
    logic [AW-1:0] m_axi_araddr;
    logic [IW-1:0] m_axi_arid;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic          m_axi_rvalid, m_axi_rready;
    logic [DW-1:0] m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rlast;
    logic [IW-1:0] m_axi_rid;
    logic          line_valid, line_ready;
    logic [511:0]  line_data;
    logic [AW-1:0] line_addr;
    logic          line_err;
`ifdef LINE_FILL_CWF_EN
    logic          cw_valid;
    logic [DW-1:0] cw_data;
`endif

    int errors = 0;
    int checks = 0;
    logic [511:0] exp_line;
    logic [63:0]  exp_araddr;

    axi_line_fill #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FILL_ID('0)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
        .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rid(m_axi_rid),
        .line_valid(line_valid), .line_ready(line_ready), .line_data(line_data),
        .line_addr(line_addr), .line_err(line_err)
`ifdef LINE_FILL_CWF_EN
        , .cw_valid(cw_valid), .cw_data(cw_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Request in IDLE, then hold ADDR for ar_delay cycles before arready.
    task automatic issue(input logic [63:0] addr, input int ar_delay, input bit hold);
        req_valid = 1'b1; req_addr = addr;
        m_axi_rvalid = 1'b1; m_axi_rdata = BAD; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
        m_axi_arready = 1'b0;
        chk("req_ready_idle", req_ready, 1);
        tick();
        exp_araddr = addr & ~64'h7;
        if (hold) begin
            req_valid = 1'b1; req_addr = 64'h1234_5640;
        end else begin
            req_valid = 1'b0;
        end
        for (int d = 0; d < ar_delay; d++) begin
            chk("arvalid_wait", m_axi_arvalid, 1);
            chk("araddr_wait", m_axi_araddr, exp_araddr);
            chk("req_ready_addr", req_ready, 0);
            tick();
        end
        chk("arvalid", m_axi_arvalid, 1);
        chk("araddr", m_axi_araddr, exp_araddr);
        chk("arid", m_axi_arid, 0);
        chk("arlen", m_axi_arlen, 7);
        chk("arsize", m_axi_arsize, 3);
        chk("arburst", m_axi_arburst, 2);
        chk("rready_addr", m_axi_rready, 0);
        m_axi_arready = 1'b1;
        tick();
        m_axi_arready = 1'b0;
        chk("arvalid_drop", m_axi_arvalid, 0);
        chk("rready_data", m_axi_rready, 1);
    endtask

    task automatic do_beats(input logic [63:0] base, input int start, input int nbeats,
                            input int rlast_at, input int err_at, input bit gaps);
        for (int k = 0; k < nbeats; k++) begin
            if (gaps) begin
                m_axi_rvalid = 1'b0; m_axi_rdata = BAD; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
                tick();
`ifdef LINE_FILL_CWF_EN
                chk("cw_valid_gap", cw_valid, 0);
`endif
            end
            chk("rready_beat", m_axi_rready, 1);
            chk("line_valid_busy", line_valid, 0);
            chk("araddr_stable", m_axi_araddr, exp_araddr);
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = base + 64'(k);
            m_axi_rlast  = (k == rlast_at);
            m_axi_rresp  = (k == err_at) ? 2'b10 : 2'b00;
            tick();
            exp_line[((start + k) % 8) * 64 +: 64] = base + 64'(k);
`ifdef LINE_FILL_CWF_EN
            chk("cw_valid", cw_valid, (k == 0));
            if (k == 0) chk("cw_data", cw_data, base);
`endif
        end
        m_axi_rvalid = 1'b1; m_axi_rdata = BAD; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
    endtask

    // Hold line_ready low nlow cycles, then handshake.
    task automatic wait_resp(input int nlow, input logic [63:0] addr, input logic exp_err);
        for (int i = 0; i < nlow; i++) begin
            chk("line_valid_hold", line_valid, 1);
            chk("line_data_hold", line_data, exp_line);
            chk("req_ready_resp", req_ready, 0);
            tick();
        end
        chk("line_valid", line_valid, 1);
        chk("line_data", line_data, exp_line);
        chk("line_addr", line_addr, addr & ~64'h3F);
        chk("line_err", line_err, exp_err);
        chk("req_ready_resp", req_ready, 0);
        req_valid  = 1'b0;
        line_ready = 1'b1;
        tick();
        line_ready = 1'b0;
        chk("line_valid_done", line_valid, 0);
        chk("req_ready_done", req_ready, 1);
        chk("line_err_clear", line_err, 0);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_addr = '0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
        m_axi_rresp = 2'b00; m_axi_rlast = 1'b0; m_axi_rid = '0; line_ready = 1'b0;
        exp_line = '0; exp_araddr = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_arvalid", m_axi_arvalid, 0);
        chk("rst_rready", m_axi_rready, 0);
        chk("rst_line_valid", line_valid, 0);
        chk("rst_line_err", line_err, 0);
        chk("rst_line_data", line_data, 0);
        chk("rst_line_addr", line_addr, 0);
`ifdef LINE_FILL_CWF_EN
        chk("rst_cw_valid", cw_valid, 0);
`endif

        // aligned line, zero-wait slave: line_valid lands at cycle 10
        issue(64'h8000_1000, 0, 0);
        do_beats(64'h0, 0, 8, 7, -1, 0);
        chk("t1_word7", line_data[7*64 +: 64], 64'h7);
        wait_resp(0, 64'h8000_1000, 1'b0);

        // critical word 5: wrap order 5,6,7,0..4
        issue(64'h8000_1028, 0, 0);
        do_beats(64'h10, 5, 8, 7, -1, 0);
        chk("t2_word5", line_data[5*64 +: 64], 64'h10);
        chk("t2_word0", line_data[0*64 +: 64], 64'h13);
        chk("t2_word4", line_data[4*64 +: 64], 64'h17);
        chk("t2_line_addr", line_addr, 64'h8000_1000);
        wait_resp(1, 64'h8000_1028, 1'b0);

        // slave error on beat 3, then a clean fill
        issue(64'h8000_2000, 0, 0);
        do_beats(64'h20, 0, 8, 7, 3, 0);
        wait_resp(0, 64'h8000_2000, 1'b1);
        issue(64'h8000_2040, 0, 0);
        do_beats(64'h30, 0, 8, 7, -1, 0);
        wait_resp(0, 64'h8000_2040, 1'b0);

        // stalled AR, gappy R, slow consumer, pending second request
        issue(64'h8000_3010, 4, 1);
        do_beats(64'hA0, 2, 8, 7, -1, 1);
        chk("t4_word0", line_data[0*64 +: 64], 64'hA6);
        chk("t4_word2", line_data[2*64 +: 64], 64'hA0);
        wait_resp(5, 64'h8000_3010, 1'b0);

        // early rlast on 6th beat
        issue(64'h8000_4000, 0, 0);
        do_beats(64'h50, 0, 6, 5, -1, 0);
        wait_resp(0, 64'h8000_4000, 1'b1);

        // reset in the middle of DATA
        issue(64'h8000_5000, 0, 0);
        do_beats(64'h60, 0, 3, -1, -1, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_line = '0;
        chk("mid_rst_arvalid", m_axi_arvalid, 0);
        chk("mid_rst_rready", m_axi_rready, 0);
        chk("mid_rst_line_valid", line_valid, 0);
        chk("mid_rst_line_err", line_err, 0);
        chk("mid_rst_req_ready", req_ready, 1);
        chk("mid_rst_line_data", line_data, 0);

        // critical-word forward case
        issue(64'h4000_0018, 0, 0);
        do_beats(64'hDEAD_BEEF, 3, 8, 7, -1, 0);
        chk("t7_word3", line_data[3*64 +: 64], 64'hDEAD_BEEF);
        wait_resp(2, 64'h4000_0018, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
